// File: rtl/vga_pix_fetch.sv
// Pixel source for vga_ctrl: unpacks two 24-bit pixels per 64-bit FWFT word
// and tracks frame position, restarting on every vsync rising edge.
module vga_pix_fetch #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter logic [23:0] FILL_RGB = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        pix_req,
    input  logic [63:0] fifo_rd_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        frame_start,
    output logic [23:0] rgb_out,
    output logic [15:0] underflow_cnt
);

    localparam logic [18:0] LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [18:0] cnt_q, cnt_d;
    logic [23:0] rgb_q, rgb_d;
    logic [15:0] ufl_q, ufl_d;
    logic        vsync_q;
    logic        fs_q;
    logic        fs_cond;
    logic        unused_pad;

    assign unused_pad = ^{fifo_rd_data[63:56], fifo_rd_data[31:24]};

    assign fs_cond       = ~vsync_q & vsync;
    assign frame_start   = fs_q;
    assign rgb_out       = rgb_q;
    assign underflow_cnt = ufl_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        rgb_d      = rgb_q;
        ufl_d      = ufl_q;
        fifo_rd_en = 1'b0;
        if (fs_cond) begin
            // a frame start wins over any request in the same cycle
            state_d = ACTIVE;
            sel_d   = 1'b0;
            cnt_d   = '0;
        end else if (pix_req) begin
            unique case (state_q)
                ACTIVE: begin
                    cnt_d = cnt_q + 19'd1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                    if (fifo_empty) begin
                        rgb_d = FILL_RGB;
                        if (ufl_q != 16'hFFFF) begin
                            ufl_d = ufl_q + 16'd1;
                        end
                    end else begin
                        rgb_d      = sel_q ? fifo_rd_data[55:32]
                                           : fifo_rd_data[23:0];
                        sel_d      = ~sel_q;
                        fifo_rd_en = sel_q;
                    end
                end
                default: begin
                    rgb_d = FILL_RGB;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            rgb_q   <= '0;
            ufl_q   <= '0;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rgb_q   <= rgb_d;
            ufl_q   <= ufl_d;
            vsync_q <= vsync;
            fs_q    <= fs_cond;
        end
    end

endmodule

// File: tb/tb_vga_pix_fetch.sv
// Scoreboard bench for vga_pix_fetch: small frame (4x2) on one instance,
// underflow-counter saturation on a second, taller-frame instance.
module tb_vga_pix_fetch;

    localparam logic [23:0] FILL = 24'hF0F0F0;

    logic        clk = 1'b0;
    logic        rst, vsync, pix_req, fifo_empty;
    logic [63:0] fifo_rd_data;
    logic        fifo_rd_en, frame_start;
    logic [23:0] rgb_out;
    logic [15:0] underflow_cnt;

    logic        rst2, vsync2, req2;
    logic        rd_en2, fs2;
    logic [23:0] rgb2;
    logic [15:0] ufl2;

    always #5 clk = ~clk;

    vga_pix_fetch #(.H_ACTIVE(4), .V_ACTIVE(2), .FILL_RGB(FILL)) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .pix_req(pix_req),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .frame_start(frame_start),
        .rgb_out(rgb_out), .underflow_cnt(underflow_cnt)
    );

    vga_pix_fetch #(.H_ACTIVE(4), .V_ACTIVE(16385), .FILL_RGB(FILL)) dut2 (
        .clk(clk), .rst(rst2), .vsync(vsync2), .pix_req(req2),
        .fifo_rd_data(64'h0), .fifo_empty(1'b1),
        .fifo_rd_en(rd_en2), .frame_start(fs2),
        .rgb_out(rgb2), .underflow_cnt(ufl2)
    );

    int          asserts = 0;
    int          fails   = 0;
    int          pops    = 0;
    int          fs_cnt  = 0;
    logic        req_prev = 1'b0;
    logic        pop_pend = 1'b0;
    logic [63:0] fq[$];
    logic [23:0] exp_rgb[$];
    logic        exp_rd[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void upd();
        fifo_empty = (fq.size() == 0);
        if (fq.size() > 0) fifo_rd_data = fq[0];
        else fifo_rd_data = 64'h0;
    endfunction

    // Monitor: rgb_out answers the previous cycle's request,
    // fifo_rd_en answers the current one.
    always @(negedge clk) begin
        if (req_prev) begin
            asserts++;
            if (exp_rgb.size() == 0) begin
                fails++;
                $display("FAIL rgb_sb: output with no expectation");
            end else begin
                automatic logic [23:0] e = exp_rgb.pop_front();
                asserts--;
                check("rgb_out", {8'h0, rgb_out}, {8'h0, e});
            end
        end
        if (pix_req) begin
            asserts++;
            if (exp_rd.size() == 0) begin
                fails++;
                $display("FAIL rd_sb: request with no expectation");
            end else begin
                automatic logic e2 = exp_rd.pop_front();
                asserts--;
                check("fifo_rd_en", {31'h0, fifo_rd_en}, {31'h0, e2});
            end
        end
        check("rd_while_empty", {31'h0, fifo_rd_en & fifo_empty}, 32'h0);
        req_prev = pix_req;
        pop_pend = fifo_rd_en;
        if (fifo_rd_en) pops++;
        if (frame_start) fs_cnt++;
    end

    task automatic tick(input logic req, input logic vs,
                        input logic [23:0] er, input logic erd);
        @(posedge clk);
        #1;
        if (pop_pend && fq.size() > 0) fq.delete(0);
        #1;
        pix_req = req;
        vsync   = vs;
        if (req) begin
            exp_rgb.push_back(er);
            exp_rd.push_back(erd);
        end
        upd();
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; pix_req = 1'b0;
        rst2 = 1'b1; vsync2 = 1'b1; req2 = 1'b0;
        upd();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        rst2 = 1'b0;

        // reset / idle
        tick(1'b0, 1'b1, 24'h0, 1'b0);
        check("rst_rgb", {8'h0, rgb_out}, 32'h0);
        check("rst_fs", {31'h0, frame_start}, 32'h0);
        check("rst_ufl", {16'h0, underflow_cnt}, 32'h0);
        check("rst_rd", {31'h0, fifo_rd_en}, 32'h0);
        tick(1'b1, 1'b1, FILL, 1'b0);
        tick(1'b0, 1'b1, 24'h0, 1'b0);
        tick(1'b1, 1'b1, FILL, 1'b0);
        tick(1'b0, 1'b1, 24'h0, 1'b0);
        check("idle_fs_cnt", fs_cnt, 0);
        check("idle_pops", pops, 0);
        check("idle_ufl", {16'h0, underflow_cnt}, 32'h0);

        // normal frame
        fq.push_back(64'h00000002_00000001);
        fq.push_back(64'h00000004_00000003);
        fq.push_back(64'h00000006_00000005);
        fq.push_back(64'h00000008_00000007);
        upd();
        tick(1'b0, 1'b0, 24'h0, 1'b0);
        tick(1'b0, 1'b1, 24'h0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b1, 24'(i), (i % 2) == 0);
            if (i == 1) check("frame_start", {31'h0, frame_start}, 32'h1);
            if (i == 2) check("fs_one_cycle", {31'h0, frame_start}, 32'h0);
        end
        tick(1'b0, 1'b1, 24'h0, 1'b0);
        check("frame_pops", pops, 4);
        check("frame_fs_cnt", fs_cnt, 1);
        check("frame_fifo_left", fq.size(), 0);

        // excess requests in DONE
        fq.push_back(64'h0000000A_00000009);
        upd();
        repeat (3) tick(1'b1, 1'b1, FILL, 1'b0);
        tick(1'b0, 1'b1, 24'h0, 1'b0);
        check("excess_ufl", {16'h0, underflow_cnt}, 32'h0);
        check("excess_pops", pops, 4);
        check("excess_fifo_left", fq.size(), 1);

        // underflow; pix_cnt keeps counting through it
        fq.delete();
        fq.push_back(64'h00000002_00000001);
        upd();
        tick(1'b0, 1'b0, 24'h0, 1'b0);
        tick(1'b0, 1'b1, 24'h0, 1'b0);
        tick(1'b1, 1'b1, 24'h1, 1'b0);
        tick(1'b1, 1'b1, 24'h2, 1'b1);
        tick(1'b1, 1'b1, FILL, 1'b0);
        tick(1'b1, 1'b1, FILL, 1'b0);
        tick(1'b0, 1'b1, 24'h0, 1'b0);
        check("ufl_cnt", {16'h0, underflow_cnt}, 32'h2);
        fq.push_back(64'h00000012_00000011);
        fq.push_back(64'h00000014_00000013);
        upd();
        tick(1'b1, 1'b1, 24'h11, 1'b0);
        tick(1'b1, 1'b1, 24'h12, 1'b1);
        tick(1'b1, 1'b1, 24'h13, 1'b0);
        tick(1'b1, 1'b1, 24'h14, 1'b1);
        tick(1'b1, 1'b1, FILL, 1'b0);
        tick(1'b0, 1'b1, 24'h0, 1'b0);
        check("ufl_done_hold", {16'h0, underflow_cnt}, 32'h2);
        check("ufl_pops", pops, 7);
        check("ufl_fs_cnt", fs_cnt, 2);

        // mid-frame restart with sel == 1
        fq.delete();
        fq.push_back(64'h00000022_00000021);
        fq.push_back(64'h00000024_00000023);
        upd();
        tick(1'b0, 1'b0, 24'h0, 1'b0);
        tick(1'b0, 1'b1, 24'h0, 1'b0);
        tick(1'b1, 1'b1, 24'h21, 1'b0);
        tick(1'b1, 1'b1, 24'h22, 1'b1);
        tick(1'b1, 1'b1, 24'h23, 1'b0);
        tick(1'b0, 1'b0, 24'h0, 1'b0);
        tick(1'b1, 1'b1, 24'h23, 1'b0);
        tick(1'b1, 1'b1, 24'h23, 1'b0);
        check("restart_fs", {31'h0, frame_start}, 32'h1);
        tick(1'b1, 1'b1, 24'h24, 1'b1);
        tick(1'b0, 1'b1, 24'h0, 1'b0);
        check("restart_pops", pops, 9);
        check("restart_fs_cnt", fs_cnt, 4);
        check("restart_ufl", {16'h0, underflow_cnt}, 32'h2);

        // saturation on the tall-frame instance
        @(posedge clk); #2 vsync2 = 1'b0;
        @(posedge clk); #2 vsync2 = 1'b1;
        @(posedge clk); #2 req2 = 1'b1;
        repeat (65534) @(posedge clk);
        #2;
        check("sat_fffe", {16'h0, ufl2}, 32'hFFFE);
        repeat (3) @(posedge clk);
        #2;
        check("sat_ffff", {16'h0, ufl2}, 32'hFFFF);
        check("sat_rgb", {8'h0, rgb2}, {8'h0, FILL});
        check("sat_rd", {31'h0, rd_en2}, 32'h0);
        repeat (3) @(posedge clk);
        #2 req2 = 1'b0;
        check("sat_hold", {16'h0, ufl2}, 32'hFFFF);
        rst2 = 1'b1;
        @(posedge clk);
        #2 rst2 = 1'b0;
        check("sat_rst", {16'h0, ufl2}, 32'h0);

        check("sb_rgb_drained", exp_rgb.size(), 0);
        check("sb_rd_drained", exp_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
